// File: rtl/latch_bank_pkg.sv
// latch_bank_pkg
// Shared helpers for the sticky event latch bank:
//   idx_width  - width of a channel index, never less than one bit
//   lowest_set - priority encoder returning the lowest set bit position
// Vectors handed to lowest_set are zero-extended to MAX_WIDTH bits, so
// the bank supports up to MAX_WIDTH channels.
package latch_bank_pkg;

    localparam int MAX_WIDTH = 64;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Scan from the top down so the last hit written is the lowest index.
    function automatic int lowest_set(input logic [MAX_WIDTH-1:0] vec);
        int idx;
        idx = 0;
        for (int i = MAX_WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/latch_bank_if.sv
// latch_bank_if
// Bundles the channel-facing signals of the latch bank.
//   raw         - asynchronous button levels (master -> slave)
//   clr         - per-channel sticky clear mask (master -> slave)
//   first_ack   - consumes the first-event capture (master -> slave)
//   stable      - debounced levels (slave -> master)
//   press       - one-cycle rising pulses (slave -> master)
//   q, any_q    - sticky flags and their OR (slave -> master)
//   first_valid - a first-event capture is held (slave -> master)
//   first_idx   - captured channel index (slave -> master)
interface latch_bank_if
    import latch_bank_pkg::*;
#(
    parameter int WIDTH = 4
);
    localparam int IW = idx_width(WIDTH);

    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] clr;
    logic             first_ack;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] q;
    logic             any_q;
    logic             first_valid;
    logic [IW-1:0]    first_idx;

    modport master (
        output raw, clr, first_ack,
        input  stable, press, q, any_q, first_valid, first_idx
    );

    modport slave (
        input  raw, clr, first_ack,
        output stable, press, q, any_q, first_valid, first_idx
    );

endinterface

// File: rtl/debounce_channel.sv
// debounce_channel
// One input channel: two-flop synchroniser, debounce counter, stable
// level register and a registered rising-edge pulse.
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   raw    - asynchronous level input
//   stable - debounced level
//   press  - one-cycle pulse on a stable 0->1 transition
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_reg;
    logic          s2_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          stable_reg;
    logic          stable_next;
    logic          press_reg;
    logic          press_next;

    // A sample matching the stable level restarts the count, so a glitch
    // back to the old level throws away any progress towards a change.
    always_comb begin
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        if (s2_reg == stable_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
            stable_next = s2_reg;
            cnt_next    = '0;
        end else begin
            cnt_next = cnt_reg + CW'(1);
        end
        // Registered alongside stable so the pulse lines up with the rise.
        press_next = stable_next & ~stable_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg     <= 1'b0;
            s2_reg     <= 1'b0;
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
            press_reg  <= 1'b0;
        end else begin
            s1_reg     <= raw;
            s2_reg     <= s1_reg;
            cnt_reg    <= cnt_next;
            stable_reg <= stable_next;
            press_reg  <= press_next;
        end
    end

    assign stable = stable_reg;
    assign press  = press_reg;

endmodule

// File: rtl/latch_bank.sv
// latch_bank
// Bank of WIDTH sticky event latches fed by debounced button inputs,
// plus a capture of the first channel to fire since the last acknowledge.
//   clk   - clock, all state on its rising edge
//   rst_n - asynchronous active-low reset
//   bus   - latch_bank_if slave: raw/clr/first_ack in,
//           stable/press/q/any_q/first_valid/first_idx out
module latch_bank
    import latch_bank_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    latch_bank_if.slave  bus
);

    localparam int IW = idx_width(WIDTH);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             first_valid_reg;
    logic             first_valid_next;
    logic [IW-1:0]    first_idx_reg;
    logic [IW-1:0]    first_idx_next;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (bus.raw[gi]),
            .stable (stable[gi]),
            .press  (press[gi])
        );

        // Set beats clear so a press landing with a clear is never lost.
        always_comb begin
            q_next[gi] = q_reg[gi];
            if (press[gi]) begin
                q_next[gi] = 1'b1;
            end else if (bus.clr[gi]) begin
                q_next[gi] = 1'b0;
            end
        end
    end

    // An acknowledge frees the capture slot in the same cycle, so a press
    // arriving with the ack becomes the new capture rather than being lost.
    always_comb begin
        first_valid_next = first_valid_reg;
        first_idx_next   = first_idx_reg;
        if ((!first_valid_reg || bus.first_ack) && (press != '0)) begin
            first_valid_next = 1'b1;
            first_idx_next   = IW'(lowest_set(MAX_WIDTH'(press)));
        end else if (bus.first_ack) begin
            first_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg           <= RESET_VALUE;
            first_valid_reg <= 1'b0;
            first_idx_reg   <= '0;
        end else begin
            q_reg           <= q_next;
            first_valid_reg <= first_valid_next;
            first_idx_reg   <= first_idx_next;
        end
    end

    assign bus.stable      = stable;
    assign bus.press       = press;
    assign bus.q           = q_reg;
    assign bus.any_q       = |q_reg;
    assign bus.first_valid = first_valid_reg;
    assign bus.first_idx   = first_idx_reg;

endmodule

// File: tb/tb_latch_bank.sv
// tb_latch_bank
// Directed steps for the main behaviours followed by random stimulus,
// with every cycle compared against a behavioural model of the bank.
module tb_latch_bank;

    localparam int               W  = 4;
    localparam int               D  = 4;
    localparam logic [W-1:0]     RV = 4'b0101;

    logic clk;
    logic rst_n;

    latch_bank_if #(.WIDTH(W)) bus ();

    latch_bank #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .RESET_VALUE     (RV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [W-1:0] m_s1, m_s2, m_stable, m_press, m_q;
    logic         m_fv;
    int           m_idx;
    logic [D-1:0] hist [W];   // last D synchronised samples per channel
    int           since [W];  // edges since the stable level last changed

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int lowest(input logic [W-1:0] v);
        for (int i = 0; i < W; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_press = '0;
        m_q = RV; m_fv = 1'b0; m_idx = 0;
        for (int i = 0; i < W; i++) begin
            hist[i]  = '0;
            since[i] = 0;
        end
    endtask

    // One clock edge of the specified behaviour, from pre-edge values.
    task automatic model_step();
        logic [W-1:0] new_stable;
        for (int i = 0; i < W; i++) begin
            if (m_press[i])         m_q[i] = 1'b1;
            else if (bus.clr[i])    m_q[i] = 1'b0;
        end
        if ((!m_fv || bus.first_ack) && m_press != '0) begin
            m_fv  = 1'b1;
            m_idx = lowest(m_press);
        end else if (bus.first_ack) begin
            m_fv = 1'b0;
        end
        new_stable = m_stable;
        for (int i = 0; i < W; i++) begin
            hist[i] = (hist[i] << 1) | D'(m_s2[i]);
            since[i]++;
            // A change needs D consecutive differing samples since the last change.
            if (since[i] >= D && hist[i] == {D{~m_stable[i]}}) begin
                new_stable[i] = ~m_stable[i];
                since[i] = 0;
            end
        end
        m_press  = new_stable & ~m_stable;
        m_stable = new_stable;
        m_s2 = m_s1;
        m_s1 = bus.raw;
    endtask

    task automatic check_all(input string where);
        chk({where, ".stable"},      32'(bus.stable),      32'(m_stable));
        chk({where, ".press"},       32'(bus.press),       32'(m_press));
        chk({where, ".q"},           32'(bus.q),           32'(m_q));
        chk({where, ".any_q"},       32'(bus.any_q),       32'(|m_q));
        chk({where, ".first_valid"}, 32'(bus.first_valid), 32'(m_fv));
        chk({where, ".first_idx"},   32'(bus.first_idx),   32'(m_idx));
    endtask

    task automatic cyc(input string where);
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_all(where);
        $display("cycle t=%0t %s raw=%b clr=%b ack=%b stable=%b press=%b q=%b fv=%b idx=%0d",
                 $time, where, bus.raw, bus.clr, bus.first_ack, bus.stable, bus.press,
                 bus.q, bus.first_valid, bus.first_idx);
    endtask

    task automatic cycles(input int n, input string where);
        for (int k = 0; k < n; k++) cyc(where);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.raw = '0; bus.clr = '0; bus.first_ack = 1'b0;
        model_reset();

        // Reset values
        cycles(3, "reset");
        chk("rst_q", 32'(bus.q), 32'(4'b0101));
        chk("rst_any_q", 32'(bus.any_q), 32'd1);
        chk("rst_stable", 32'(bus.stable), 32'd0);
        chk("rst_press", 32'(bus.press), 32'd0);
        chk("rst_fv", 32'(bus.first_valid), 32'd0);
        rst_n = 1'b1;

        bus.clr = 4'hF;
        cyc("clr_all");
        bus.clr = '0;
        chk("clr_all_q", 32'(bus.q), 32'd0);

        // Clean press on channel 2
        bus.raw = 4'b0100;
        cycles(5, "clean");            // E0..E4
        chk("clean_no_early_press", 32'(bus.press), 32'd0);
        cyc("clean");                  // E5
        chk("clean_press", 32'(bus.press), 32'(4'b0100));
        chk("clean_q_not_yet", 32'(bus.q), 32'd0);
        cyc("clean");                  // E6
        chk("clean_press_one_cycle", 32'(bus.press), 32'd0);
        chk("clean_q", 32'(bus.q), 32'(4'b0100));
        chk("clean_fv", 32'(bus.first_valid), 32'd1);
        chk("clean_idx", 32'(bus.first_idx), 32'd2);

        bus.first_ack = 1'b1; bus.clr = 4'b0100;
        cyc("ack");
        bus.first_ack = 1'b0; bus.clr = '0;
        chk("ack_fv", 32'(bus.first_valid), 32'd0);
        chk("ack_q", 32'(bus.q), 32'd0);

        // Glitch on channel 1 shorter than the debounce window
        bus.raw = 4'b0110;
        cycles(3, "glitch");
        bus.raw = 4'b0100;
        cycles(8, "glitch");
        chk("glitch_stable", 32'(bus.stable), 32'(4'b0100));
        chk("glitch_q", 32'(bus.q), 32'd0);

        // Set/clear collision on channel 0
        bus.raw = 4'b0101;
        cycles(6, "collide");          // E0..E5
        chk("collide_press", 32'(bus.press), 32'(4'b0001));
        bus.clr = 4'b0001;
        cyc("collide");                // set wins
        chk("collide_set_wins", 32'(bus.q[0]), 32'd1);
        cyc("collide");                // plain clear
        bus.clr = '0;
        chk("collide_clear", 32'(bus.q[0]), 32'd0);
        bus.first_ack = 1'b1;
        cyc("collide_ack");
        bus.first_ack = 1'b0;

        // First capture holds against later presses
        bus.raw = 4'b1101;
        cycles(7, "first3");
        chk("first3_idx", 32'(bus.first_idx), 32'd3);
        bus.raw = 4'b1111;
        cycles(7, "first1_noack");
        chk("first_hold_idx", 32'(bus.first_idx), 32'd3);
        chk("first_hold_fv", 32'(bus.first_valid), 32'd1);
        bus.raw = 4'b1101;
        cycles(7, "ch1_fall");
        bus.raw = 4'b1111;
        cycles(6, "ch1_rise");         // press[1] now high
        chk("ch1_press", 32'(bus.press), 32'(4'b0010));
        bus.first_ack = 1'b1;
        cyc("ack_with_press");
        bus.first_ack = 1'b0;
        chk("ackpress_fv", 32'(bus.first_valid), 32'd1);
        chk("ackpress_idx", 32'(bus.first_idx), 32'd1);
        bus.first_ack = 1'b1;
        cyc("lone_ack");
        bus.first_ack = 1'b0;
        chk("lone_ack_fv", 32'(bus.first_valid), 32'd0);

        // Simultaneous presses
        bus.raw = 4'b0000;
        cycles(8, "release");
        bus.clr = 4'hF;
        cyc("clr_all2");
        bus.clr = '0;
        bus.raw = 4'b1010;
        cycles(6, "simul");
        chk("simul_press", 32'(bus.press), 32'(4'b1010));
        cyc("simul");
        chk("simul_q", 32'(bus.q), 32'(4'b1010));
        chk("simul_idx", 32'(bus.first_idx), 32'd1);
        chk("simul_fv", 32'(bus.first_valid), 32'd1);

        // Asynchronous reset in mid-cycle
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_q", 32'(bus.q), 32'(4'b0101));
        chk("async_stable", 32'(bus.stable), 32'd0);
        chk("async_fv", 32'(bus.first_valid), 32'd0);
        #3;
        rst_n = 1'b1;
        cycles(5, "post_reset");       // raw still high: full latency restarts
        chk("post_reset_no_press", 32'(bus.press), 32'd0);
        cyc("post_reset");
        chk("post_reset_press", 32'(bus.press), 32'(4'b1010));

        // Random stimulus against the model
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 5) == 0) bus.raw[i] = ~bus.raw[i];
                bus.clr[i] = ($urandom_range(0, 7) == 0);
            end
            bus.first_ack = ($urandom_range(0, 4) == 0);
            if (n == 200) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all("rand_reset");
                #2;
                rst_n = 1'b1;
            end
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
